// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of unmapped pregs for RENAME.
// It offers two pregs per cycle, allocates 0-2 per cycle and takes back up to 2 released pregs per cycle.
module free_list #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_AREGS = 32,
  localparam int DEPTH     = NUM_PREGS - NUM_AREGS,
  localparam int PREG_W    = $clog2(NUM_PREGS),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_alloc_num,
  input  logic              i_release_en   [0:1],
  input  logic [PREG_W-1:0] i_release_preg [0:1],
  output logic [PREG_W-1:0] o_free_pregs   [0:1],
  output logic              o_alloc_ready,
  output logic [CNT_W-1:0]  o_free_count,
  output logic              o_underflow,
  output logic              o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = PTR_W + 2;

  logic [PREG_W-1:0] r_mem [0:DEPTH-1];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_underflow;
  logic              r_overflow;

  logic              w_alloc_legal;
  logic [1:0]        w_alloc_amt;
  logic [CNT_W-1:0]  w_count_after_alloc;
  logic [CNT_W-1:0]  w_count_mid;
  logic [1:0]        w_push_valid;
  logic [1:0]        w_push_accept;
  logic [1:0]        w_push_num;
  logic              w_overflow_hit;
  logic              w_wr_en0;
  logic              w_wr_en1;
  logic [PTR_W-1:0]  w_wr_addr0;
  logic [PTR_W-1:0]  w_wr_addr1;
  logic [PREG_W-1:0] w_wr_data0;
  logic [PREG_W-1:0] w_wr_data1;

  // Modulo-DEPTH pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(inc);
    if (sum >= SUM_W'(DEPTH))
      sum = sum - SUM_W'(DEPTH);
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    w_alloc_legal       = (i_alloc_num != 2'd3) && (CNT_W'(i_alloc_num) <= r_count);
    w_alloc_amt         = w_alloc_legal ? i_alloc_num : 2'd0;
    w_count_after_alloc = r_count - CNT_W'(w_alloc_amt);

    // Room for a push is judged after this cycle's pops; lane 0 claims space first.
    w_push_valid[0]  = i_release_en[0] && (i_release_preg[0] != '0);
    w_push_valid[1]  = i_release_en[1] && (i_release_preg[1] != '0);
    w_push_accept[0] = w_push_valid[0] && (w_count_after_alloc < CNT_W'(DEPTH));
    w_count_mid      = w_count_after_alloc + CNT_W'(w_push_accept[0]);
    w_push_accept[1] = w_push_valid[1] && (w_count_mid < CNT_W'(DEPTH));
    w_overflow_hit   = |(w_push_valid & ~w_push_accept);
    w_push_num       = {1'b0, w_push_accept[0]} + {1'b0, w_push_accept[1]};

    // Accepted lanes are compacted onto tail, tail+1.
    w_wr_en0   = |w_push_accept;
    w_wr_addr0 = r_tail;
    w_wr_data0 = w_push_accept[0] ? i_release_preg[0] : i_release_preg[1];
    w_wr_en1   = &w_push_accept;
    w_wr_addr1 = wrap_add(r_tail, 2'd1);
    w_wr_data1 = i_release_preg[1];
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (i_rst)
        r_mem[k] <= PREG_W'(NUM_AREGS + k);
      else if (w_wr_en0 && (w_wr_addr0 == PTR_W'(k)))
        r_mem[k] <= w_wr_data0;
      else if (w_wr_en1 && (w_wr_addr1 == PTR_W'(k)))
        r_mem[k] <= w_wr_data1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= CNT_W'(DEPTH);
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_head  <= wrap_add(r_head, w_alloc_amt);
      r_tail  <= wrap_add(r_tail, w_push_num);
      r_count <= w_count_after_alloc + CNT_W'(w_push_num);
      if (!w_alloc_legal)
        r_underflow <= 1'b1;
      if (w_overflow_hit)
        r_overflow <= 1'b1;
    end
  end

  assign o_free_pregs[0] = r_mem[r_head];
  assign o_free_pregs[1] = r_mem[wrap_add(r_head, 2'd1)];
  assign o_alloc_ready   = (r_count >= CNT_W'(2));
  assign o_free_count    = r_count;
  assign o_underflow     = r_underflow;
  assign o_overflow      = r_overflow;

endmodule
